// File: rtl/p405s_timer_pit_dp_if.sv
// p405s_timer_pit_dp_if: control, SPR-write and status signals between the PIT equations/SPR logic and the PIT datapath.
interface p405s_timer_pit_dp_if;
    logic        pit8E1;
    logic        pit8E2;
    logic        pit24E1;
    logic        pit24E2;
    logic        pitReloadE1;
    logic        pitReloadE2;
    logic [0:1]  pitMuxSel;
    logic        hwSetPitStatus;
    logic [0:31] sprDataIn;
    logic        tsrPisClr;
    logic        tcrPIE;
    logic [0:31] pitL2;
    logic [0:31] pitReloadL2;
    logic        tsrPIS;
    logic        pitIntrpt;

    modport master (
        output pit8E1, pit8E2, pit24E1, pit24E2, pitReloadE1, pitReloadE2,
               pitMuxSel, hwSetPitStatus, sprDataIn, tsrPisClr, tcrPIE,
        input  pitL2, pitReloadL2, tsrPIS, pitIntrpt
    );

    modport slave (
        input  pit8E1, pit8E2, pit24E1, pit24E2, pitReloadE1, pitReloadE2,
               pitMuxSel, hwSetPitStatus, sprDataIn, tsrPisClr, tcrPIE,
        output pitL2, pitReloadL2, tsrPIS, pitIntrpt
    );
endinterface

// File: rtl/p405s_timer_pit_dp.sv
// p405s_timer_pit_dp: PIT count/reload registers, TSR PIS status bit and registered PIT interrupt.
// The count is split into a high 24-bit field and a low byte, each with its own enable.
module p405s_timer_pit_dp #(
    parameter int              PIT_W   = 32,
    parameter logic [0:PIT_W-1] RST_PIT = '0
) (
    input logic                 CB,
    input logic                 coreReset,
    p405s_timer_pit_dp_if.slave bus
);
    logic [0:PIT_W-1] pit, rl;
    logic             pis, intr;
    logic [0:7]       lo, nxt_lo;
    logic [0:PIT_W-9] hi, nxt_hi;
    logic             en8, en24, en_rl;

    assign en8   = bus.pit8E1 & bus.pit8E2;
    assign en24  = bus.pit24E1 & bus.pit24E2;
    assign en_rl = bus.pitReloadE1 & bus.pitReloadE2;
    assign lo    = pit[PIT_W-8:PIT_W-1];
    assign hi    = pit[0:PIT_W-9];

    // Borrow from low byte into high field is decided upstream and arrives as en24.
    always_comb begin
        nxt_lo = bus.pitMuxSel == 2'b00 ? lo - 8'd1 :
                 bus.pitMuxSel == 2'b10 ? rl[PIT_W-8:PIT_W-1] :
                 bus.pitMuxSel == 2'b11 ? bus.sprDataIn[PIT_W-8:PIT_W-1] : lo;
        nxt_hi = bus.pitMuxSel == 2'b00 ? hi - (PIT_W-8)'(1) :
                 bus.pitMuxSel == 2'b10 ? rl[0:PIT_W-9] :
                 bus.pitMuxSel == 2'b11 ? bus.sprDataIn[0:PIT_W-9] : hi;
    end

    always_ff @(posedge CB) begin
        if (coreReset) begin
            pit  <= RST_PIT;
            rl   <= RST_PIT;
            pis  <= 1'b0;
            intr <= 1'b0;
        end else begin
            if (en8)   pit[PIT_W-8:PIT_W-1] <= nxt_lo;
            if (en24)  pit[0:PIT_W-9]       <= nxt_hi;
            if (en_rl) rl                   <= bus.sprDataIn;
            pis  <= bus.hwSetPitStatus | (pis & ~bus.tsrPisClr);
            intr <= pis & bus.tcrPIE;
        end
    end

    assign bus.pitL2       = pit;
    assign bus.pitReloadL2 = rl;
    assign bus.tsrPIS      = pis;
    assign bus.pitIntrpt   = intr;
endmodule

// File: tb/tb_p405s_timer_pit_dp.sv
// tb_p405s_timer_pit_dp: directed vectors feed a scoreboard queue; a negedge monitor pops and compares.
module tb_p405s_timer_pit_dp;
    logic CB = 1'b0;
    logic coreReset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int          tag;
        string       name;
        logic [65:0] exp;
    } item_t;
    item_t sb[$];

    p405s_timer_pit_dp_if bus();

    p405s_timer_pit_dp dut (
        .CB(CB),
        .coreReset(coreReset),
        .bus(bus)
    );

    always #5 CB = ~CB;
    always @(posedge CB) cyc <= cyc + 1;

    function automatic logic [65:0] mk(input logic [31:0] p, input logic [31:0] r, input logic s, input logic i);
        return {p, r, s, i};
    endfunction

    // Inputs set just after a negedge; the expectation is for the state after the next posedge.
    task automatic step(input string name, input logic rst, input logic [1:0] mux,
                        input logic e8, input logic e24, input logic erl,
                        input logic hw, input logic clr, input logic pie,
                        input logic [31:0] spr, input logic [65:0] exp);
        item_t it;
        @(negedge CB);
        #1;
        coreReset              = rst;
        bus.pitMuxSel          = mux;
        bus.pit8E1             = e8;
        bus.pit8E2             = e8;
        bus.pit24E1            = e24;
        bus.pit24E2            = e24;
        bus.pitReloadE1        = erl;
        bus.pitReloadE2        = erl;
        bus.hwSetPitStatus     = hw;
        bus.tsrPisClr          = clr;
        bus.tcrPIE             = pie;
        bus.sprDataIn          = spr;
        it.tag  = cyc + 1;
        it.name = name;
        it.exp  = exp;
        sb.push_back(it);
    endtask

    task automatic rand_reset(input string name);
        item_t it;
        @(negedge CB);
        #1;
        coreReset          = 1'b1;
        bus.pitMuxSel      = 2'($urandom_range(0, 3));
        bus.pit8E1         = 1'($urandom_range(0, 1));
        bus.pit8E2         = 1'($urandom_range(0, 1));
        bus.pit24E1        = 1'($urandom_range(0, 1));
        bus.pit24E2        = 1'($urandom_range(0, 1));
        bus.pitReloadE1    = 1'($urandom_range(0, 1));
        bus.pitReloadE2    = 1'($urandom_range(0, 1));
        bus.hwSetPitStatus = 1'($urandom_range(0, 1));
        bus.tsrPisClr      = 1'($urandom_range(0, 1));
        bus.tcrPIE         = 1'($urandom_range(0, 1));
        bus.sprDataIn      = $urandom();
        it.tag  = cyc + 1;
        it.name = name;
        it.exp  = mk(32'h0, 32'h0, 1'b0, 1'b0);
        sb.push_back(it);
    endtask

    initial begin
        logic [65:0] act;
        item_t it;
        forever begin
            @(negedge CB);
            act = {bus.pitL2, bus.pitReloadL2, bus.tsrPIS, bus.pitIntrpt};
            while (sb.size() > 0 && sb[0].tag <= cyc) begin
                it = sb.pop_front();
                checks++;
                if (it.tag != cyc || act !== it.exp) begin
                    errors++;
                    $display("FAIL %s: got pit=%h rl=%h pis=%b int=%b, want pit=%h rl=%h pis=%b int=%b (cycle %0d tag %0d)",
                             it.name, act[65:34], act[33:2], act[1], act[0],
                             it.exp[65:34], it.exp[33:2], it.exp[1], it.exp[0], cyc, it.tag);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        rand_reset("reset0");
        rand_reset("reset1");
        //    name              rst mux   e8 e24 erl hw clr pie spr            expected
        step("hold_after_rst", 0, 2'b10, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, mk(32'h0, 32'h0, 0, 0));
        step("mtspr_both",     0, 2'b11, 1, 1, 1, 0, 0, 0, 32'h0000_0103, mk(32'h103, 32'h103, 0, 0));
        step("load_100",       0, 2'b11, 1, 1, 0, 0, 0, 0, 32'h0000_0100, mk(32'h100, 32'h103, 0, 0));
        step("dec_both",       0, 2'b00, 1, 1, 0, 0, 0, 0, 32'h0,         mk(32'hFF, 32'h103, 0, 0));
        step("dec_low_only",   0, 2'b00, 1, 0, 0, 0, 0, 0, 32'h0,         mk(32'hFE, 32'h103, 0, 0));
        step("load_1",         0, 2'b11, 1, 1, 0, 0, 0, 0, 32'h1,         mk(32'h1, 32'h103, 0, 0));
        step("dec_to_zero",    0, 2'b00, 1, 0, 0, 0, 0, 0, 32'h0,         mk(32'h0, 32'h103, 0, 0));
        step("wrap_ffffffff",  0, 2'b00, 1, 1, 0, 0, 0, 0, 32'h0,         mk(32'hFFFF_FFFF, 32'h103, 0, 0));
        step("hold_rl_wr5",    0, 2'b01, 1, 1, 1, 0, 0, 0, 32'h5,         mk(32'hFFFF_FFFF, 32'h5, 0, 0));
        step("load_1_pie",     0, 2'b11, 1, 1, 0, 0, 0, 1, 32'h1,         mk(32'h1, 32'h5, 0, 0));
        step("autoreload",     0, 2'b10, 1, 1, 0, 1, 0, 1, 32'h0,         mk(32'h5, 32'h5, 1, 0));
        step("intr_rise",      0, 2'b00, 0, 0, 0, 0, 0, 1, 32'h0,         mk(32'h5, 32'h5, 1, 1));
        step("set_clr_race",   0, 2'b00, 0, 0, 0, 1, 1, 1, 32'h0,         mk(32'h5, 32'h5, 1, 1));
        step("pis_clear",      0, 2'b00, 0, 0, 0, 0, 1, 1, 32'h0,         mk(32'h5, 32'h5, 0, 1));
        step("intr_fall",      0, 2'b00, 0, 0, 0, 0, 0, 1, 32'h0,         mk(32'h5, 32'h5, 0, 0));
        step("load_a5",        0, 2'b11, 1, 1, 0, 0, 0, 0, 32'hA5A5_A5A5, mk(32'hA5A5_A5A5, 32'h5, 0, 0));
        step("test_hold",      0, 2'b01, 1, 1, 0, 0, 0, 0, 32'h1234_5678, mk(32'hA5A5_A5A5, 32'h5, 0, 0));
        step("rl_wr7",         0, 2'b01, 0, 0, 1, 0, 0, 0, 32'h7,         mk(32'hA5A5_A5A5, 32'h7, 0, 0));
        step("reload_race",    0, 2'b10, 1, 1, 1, 0, 0, 0, 32'h9,         mk(32'h7, 32'h9, 0, 0));
        step("pis_set",        0, 2'b00, 0, 0, 0, 1, 0, 1, 32'h0,         mk(32'h7, 32'h9, 1, 0));
        step("intr_on",        0, 2'b00, 0, 0, 0, 0, 0, 1, 32'h0,         mk(32'h7, 32'h9, 1, 1));
        step("pie_drop",       0, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0,         mk(32'h7, 32'h9, 1, 0));
        step("dec_high_only",  0, 2'b00, 0, 1, 0, 0, 0, 0, 32'h0,         mk(32'hFFFF_FF07, 32'h9, 1, 0));
        step("reload_low_only",0, 2'b10, 1, 0, 0, 0, 0, 0, 32'h0,         mk(32'hFFFF_FF09, 32'h9, 1, 0));
        step("reset_mid",      1, 2'b00, 1, 1, 1, 1, 0, 1, 32'hFFFF_FFFF, mk(32'h0, 32'h0, 0, 0));
        step("post_reset",     0, 2'b00, 0, 0, 0, 0, 0, 1, 32'h0,         mk(32'h0, 32'h0, 0, 0));
        repeat (3) @(negedge CB);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/p405s_timer_pit_dp.md
Name: p405s_timer_pit_dp

Overview:
Programmable Interval Timer datapath. It holds the 32-bit PIT count register, the PIT auto-reload register and the TSR PIT status bit, and drives the PIT interrupt request. It consumes the enable and mux-select controls produced by the PIT equations block. It returns the current count (pitL2) to that block and to the SPR read mux.

Parameters:
PIT_W, 32, PIT count / reload width (the split is fixed at 24 high + 8 low; only 32 supported)
RST_PIT, 32'h0000_0000, reset value of count and reload registers

Ports:
CB  in  1  core clock
coreReset  in  1  reset; synchronous, active-high
pit8E1  in  1  low-byte update enable, phase 1
pit8E2  in  1  low-byte update enable, phase 2
pit24E1  in  1  high-24 update enable, phase 1
pit24E2  in  1  high-24 update enable, phase 2
pitReloadE1  in  1  reload-register write enable, phase 1
pitReloadE2  in  1  reload-register write enable, phase 2
pitMuxSel  in  [0:1]  next-count source select
hwSetPitStatus  in  1  PIT 1->0 transition this cycle
sprDataIn  in  [0:31]  mtSPR write data
tsrPisClr  in  1  mtSPR TSR with PIS bit set (write-1-to-clear)
tcrPIE  in  1  TCR PIT interrupt enable
pitL2  out  [0:31]  current PIT count
pitReloadL2  out  [0:31]  current reload value
tsrPIS  out  1  TSR PIT interrupt status
pitIntrpt  out  1  registered interrupt request to core

Behaviour:
- Bit 0 is the MSB throughout.
- Reset: if coreReset=1 at a CB edge: pitL2=RST_PIT, pitReloadL2=RST_PIT, tsrPIS=0, pitIntrpt=0. Reset has priority over every other input. A reset mid-countdown discards the count; no interrupt is generated.
- Effective enables: en8 = pit8E1&pit8E2; en24 = pit24E1&pit24E2; enRl = pitReloadE1&pitReloadE2. A field is updated only when its enable is 1; otherwise it holds.
- Next-value source per pitMuxSel:
  - 00: decrement. Low[24:31] <= low-1 mod 256. High[0:23] <= high-1 mod 2^24.
  - 10: reload. Load from pitReloadL2 as it was before this edge.
  - 11: SPR. Load from sprDataIn.
  - 01: test hold. Next = current pitL2, even if enables are set.
- Fields are independent. The low byte may decrement while the high field holds, or both may load together. No internal borrow logic: the borrow decision arrives already encoded in en24.
- Wrap: decrement from 0 with both enables set gives 32'hFFFF_FFFF. This is not flagged.
- Reload register: when enRl=1, pitReloadL2 <= sprDataIn. With a same-cycle mtSPR (mux 11, en8, en24 and enRl all set), count and reload both take sprDataIn.
- Reload vs reload-write in the same cycle (mux 10 and enRl): the count takes the old reload value; the reload register takes the new value.
- Status bit: set when hwSetPitStatus=1, cleared when tsrPisClr=1. If both occur in the same cycle, set wins and tsrPIS=1. Otherwise it holds.
- Interrupt: pitIntrpt <= tsrPIS & tcrPIE. Latency is one cycle after tsrPIS, two cycles after hwSetPitStatus. Clearing tcrPIE drops pitIntrpt on the next edge; tsrPIS is unaffected.
- All outputs come directly from flops; there is no combinational path from any input to any output.
- Latency: any register update is visible on pitL2 / pitReloadL2 on the edge following the enable.

Test Plan:
- Reset: drive random inputs with coreReset=1 for 2 cycles -> pitL2=0, pitReloadL2=0, tsrPIS=0, pitIntrpt=0. Release -> values hold while all enables are 0.
- mtSPR load: sprDataIn=32'h0000_0103, mux=11, en8=en24=enRl=1 for 1 cycle -> next cycle pitL2=pitReloadL2=32'h0000_0103.
- Decrement and borrow, starting from pitL2=32'h0000_0100:
  - mux=00, en8=1, en24=1 -> 32'h0000_00FF.
  - Then en8 only -> 32'h0000_00FE.
  - Then en8 only with pitL2=32'h0000_0001 -> 32'h0000_0000.
- Auto-reload and interrupt: reload=32'h0000_0005, pitL2=1, tcrPIE=1, hwSetPitStatus=1, mux=10, en8=en24=1 -> pitL2=5 and tsrPIS=1 next cycle; pitIntrpt=1 the cycle after.
- Status race: tsrPIS=1, hwSetPitStatus=1 and tsrPisClr=1 together -> tsrPIS stays 1. Next cycle tsrPisClr alone -> tsrPIS=0, and pitIntrpt=0 one cycle later.
- Test hold and reload race:
  - mux=01 with en8=en24=1, pitL2=32'hA5A5_A5A5 -> unchanged.
  - mux=10, enRl=1, old reload=7, sprDataIn=9 -> pitL2=7, pitReloadL2=9.
